// File: rtl/ifu_fetch.sv
// Instruction fetch unit: boots at RESET_PC, then fetches one instruction per next-PC handed in and delivers it to the IDU.
// Latency: npc accepted in cycle N -> AR at N+1, R at N+2, post_valid at N+3 with a zero-wait slave; each bus wait adds 1.
// Backpressure: one fetch in flight, handshake outputs held until taken; IFU_PERF_CNT_EN adds fetch/stall counters.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pre_valid,
    output logic        o_pre_ready,
    input  logic [31:0] i_ifu_npc,
    output logic        o_post_valid,
    input  logic        i_post_ready,
    output logic [31:0] o_ifu_pc,
    output logic [31:0] o_ifu_inst,
    output logic [31:0] o_araddr,
    output logic        o_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp,
    input  logic        i_rvalid,
`ifdef IFU_PERF_CNT_EN
    output logic [63:0] o_ifu_fetch_cnt,
    output logic [63:0] o_ifu_stall_cnt,
`endif
    output logic        o_rready
);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_OUT  = 3'd3,
        ST_IDLE = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pre_ready_q;
    logic        post_valid_q;
    logic        arvalid_q;
    logic        rready_q;

    // Handshake outputs are flops updated together with the state, so each one is high exactly in its own state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            inst         <= 32'h0;
            pre_ready_q  <= 1'b0;
            post_valid_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state     <= ST_AR;
                    arvalid_q <= 1'b1;
                end
                ST_AR: begin
                    if (i_arready) begin
                        state     <= ST_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (i_rvalid) begin
                        state        <= ST_OUT;
                        rready_q     <= 1'b0;
                        post_valid_q <= 1'b1;
                        // An error response delivers the all-zero word, an illegal encoding the IDU aborts on.
                        inst         <= (i_rresp == 2'b00) ? i_rdata : 32'h0;
                    end
                end
                ST_OUT: begin
                    if (i_post_ready) begin
                        state        <= ST_IDLE;
                        post_valid_q <= 1'b0;
                        pre_ready_q  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_pre_valid) begin
                        state       <= ST_AR;
                        pre_ready_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        pc          <= i_ifu_npc;
                    end
                end
                default: begin
                    state        <= ST_BOOT;
                    pre_ready_q  <= 1'b0;
                    post_valid_q <= 1'b0;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_pre_ready  = pre_ready_q;
    assign o_post_valid = post_valid_q;
    assign o_arvalid    = arvalid_q;
    assign o_rready     = rready_q;
    assign o_ifu_pc     = pc;
    assign o_ifu_inst   = inst;
    assign o_araddr     = {pc[31:2], 2'b00};

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt;
    logic [63:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= 64'h0;
            stall_cnt <= 64'h0;
        end else begin
            if (rready_q && i_rvalid)
                fetch_cnt <= fetch_cnt + 64'h1;
            if ((arvalid_q && !i_arready) || (rready_q && !i_rvalid))
                stall_cnt <= stall_cnt + 64'h1;
        end
    end

    assign o_ifu_fetch_cnt = fetch_cnt;
    assign o_ifu_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: one-cycle vector table plus hand-written wait/stall/reset sequences.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic [31:0] i_ifu_npc;
    logic        o_post_valid;
    logic        i_post_ready;
    logic [31:0] o_ifu_pc;
    logic [31:0] o_ifu_inst;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] o_ifu_fetch_cnt;
    logic [63:0] o_ifu_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_ifu_npc    (i_ifu_npc),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_ifu_pc     (o_ifu_pc),
        .o_ifu_inst   (o_ifu_inst),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
`ifdef IFU_PERF_CNT_EN
        .o_ifu_fetch_cnt (o_ifu_fetch_cnt),
        .o_ifu_stall_cnt (o_ifu_stall_cnt),
`endif
        .o_rready     (o_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        pre_valid;
        logic [31:0] npc;
        logic        post_ready;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        e_prdy;
        logic        e_pvld;
        logic        e_arv;
        logic        e_rrdy;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t v(logic r, logic pv, logic [31:0] npc, logic por, logic arr,
                               logic rvl, logic [31:0] rd, logic [1:0] rr,
                               logic ep, logic eo, logic ea, logic er,
                               logic [31:0] epc, logic [31:0] ein);
        vec_t x;
        x.rst = r; x.pre_valid = pv; x.npc = npc; x.post_ready = por; x.arready = arr;
        x.rvalid = rvl; x.rdata = rd; x.rresp = rr;
        x.e_prdy = ep; x.e_pvld = eo; x.e_arv = ea; x.e_rrdy = er; x.e_pc = epc; x.e_inst = ein;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ep, input logic eo, input logic ea,
                           input logic er, input logic [31:0] epc, input logic [31:0] ein);
        logic [31:0] eaddr;
        eaddr = {epc[31:2], 2'b00};
        chk({tag, ".pre_ready"},  64'(o_pre_ready),  64'(ep));
        chk({tag, ".post_valid"}, 64'(o_post_valid), 64'(eo));
        chk({tag, ".arvalid"},    64'(o_arvalid),    64'(ea));
        chk({tag, ".rready"},     64'(o_rready),     64'(er));
        chk({tag, ".pc"},         64'(o_ifu_pc),     64'(epc));
        chk({tag, ".inst"},       64'(o_ifu_inst),   64'(ein));
        chk({tag, ".araddr"},     64'(o_araddr),     64'(eaddr));
    endtask

    // Inputs are applied at the falling edge; outputs are sampled at the next falling edge.
    task automatic drive(input logic r, input logic pv, input logic [31:0] npc, input logic por,
                         input logic arr, input logic rvl, input logic [31:0] rd, input logic [1:0] rr);
        rst = r; i_pre_valid = pv; i_ifu_npc = npc; i_post_ready = por;
        i_arready = arr; i_rvalid = rvl; i_rdata = rd; i_rresp = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] RPC = 32'h8000_0000;

    initial begin
        rst = 1'b0; i_pre_valid = 1'b0; i_ifu_npc = 32'h0; i_post_ready = 1'b0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;

        //            rst pv npc           por arr rvl rdata         rr     prdy pvld arv rrdy pc            inst
        tbl[0]  = v(0, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, RPC,          32'h0);
        tbl[1]  = v(0, 0, 32'h0,          0, 0, 1, 32'hAAAA_AAAA, 2'b00, 0, 0, 0, 0, RPC,          32'h0);
        tbl[2]  = v(1, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 0, 0, 1, 0, RPC,          32'h0);
        tbl[3]  = v(1, 0, 32'h0,          0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 1, RPC,          32'h0);
        tbl[4]  = v(1, 1, 32'h8000_0004,  0, 0, 1, 32'h0000_0413, 2'b00, 0, 1, 0, 0, RPC,          32'h0000_0413);
        tbl[5]  = v(1, 1, 32'hDEAD_BEE0,  0, 0, 1, 32'h5555_5555, 2'b00, 0, 1, 0, 0, RPC,          32'h0000_0413);
        tbl[6]  = v(1, 0, 32'h0,          1, 0, 0, 32'h0,         2'b00, 1, 0, 0, 0, RPC,          32'h0000_0413);
        tbl[7]  = v(1, 1, 32'h8000_0004,  0, 0, 0, 32'h0,         2'b00, 0, 0, 1, 0, 32'h8000_0004, 32'h0000_0413);
        tbl[8]  = v(1, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 0, 0, 1, 0, 32'h8000_0004, 32'h0000_0413);
        tbl[9]  = v(1, 0, 32'h0,          0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 1, 32'h8000_0004, 32'h0000_0413);
        tbl[10] = v(1, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 1, 32'h8000_0004, 32'h0000_0413);
        tbl[11] = v(1, 0, 32'h0,          0, 0, 1, 32'hFFFF_FFFF, 2'b10, 0, 1, 0, 0, 32'h8000_0004, 32'h0);
        tbl[12] = v(1, 0, 32'h0,          1, 0, 0, 32'h0,         2'b00, 1, 0, 0, 0, 32'h8000_0004, 32'h0);
        tbl[13] = v(1, 1, 32'h8000_000B,  0, 0, 0, 32'h0,         2'b00, 0, 0, 1, 0, 32'h8000_000B, 32'h0);
        tbl[14] = v(1, 0, 32'h0,          0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 1, 32'h8000_000B, 32'h0);
        tbl[15] = v(1, 0, 32'h0,          0, 0, 1, 32'h1234_5678, 2'b00, 0, 1, 0, 0, 32'h8000_000B, 32'h1234_5678);
        tbl[16] = v(1, 0, 32'h0,          1, 0, 0, 32'h0,         2'b00, 1, 0, 0, 0, 32'h8000_000B, 32'h1234_5678);
        tbl[17] = v(1, 0, 32'h0,          0, 0, 0, 32'h0,         2'b00, 1, 0, 0, 0, 32'h8000_000B, 32'h1234_5678);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].pre_valid, tbl[i].npc, tbl[i].post_ready,
                  tbl[i].arready, tbl[i].rvalid, tbl[i].rdata, tbl[i].rresp);
            chk_all($sformatf("v%0d", i), tbl[i].e_prdy, tbl[i].e_pvld, tbl[i].e_arv,
                    tbl[i].e_rrdy, tbl[i].e_pc, tbl[i].e_inst);
        end
`ifdef IFU_PERF_CNT_EN
        chk("tbl.fetch_cnt", o_ifu_fetch_cnt, 64'd3);
        chk("tbl.stall_cnt", o_ifu_stall_cnt, 64'd2);
`endif

        // Address channel held off for three cycles: AR must stay asserted with a stable address.
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00);
        drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00);
        chk_all("ar_wait.start", 0, 0, 1, 0, RPC, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00);
            chk_all($sformatf("ar_wait.c%0d", k), 0, 0, 1, 0, RPC, 32'h0);
        end
        drive(1, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00);
        chk("ar_wait.early_post_valid", 64'(o_post_valid), 64'd0);
        drive(1, 0, 32'h0, 0, 0, 1, 32'h0000_0413, 2'b00);
        chk_all("ar_wait.out", 0, 1, 0, 0, RPC, 32'h0000_0413);
`ifdef IFU_PERF_CNT_EN
        chk("ar_wait.stall_cnt", o_ifu_stall_cnt, 64'd3);
        chk("ar_wait.fetch_cnt", o_ifu_fetch_cnt, 64'd1);
`endif

        // IDU stalls delivery for five cycles while the next-PC sender keeps offering.
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 32'h8000_0040, 0, 1, 1, 32'hCAFE_F00D, 2'b00);
            chk_all($sformatf("out_hold.c%0d", k), 0, 1, 0, 0, RPC, 32'h0000_0413);
        end
        drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 2'b00);
        chk_all("out_hold.idle", 1, 0, 0, 0, RPC, 32'h0000_0413);

        // Reset while a read is outstanding: fetch abandoned, stale read data ignored until R.
        drive(1, 1, 32'h8000_0010, 0, 0, 0, 32'h0, 2'b00);
        drive(1, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00);
        chk_all("rst_mid.in_r", 0, 0, 0, 1, 32'h8000_0010, 32'h0000_0413);
        drive(0, 0, 32'h0, 0, 0, 1, 32'h7777_7777, 2'b00);
        chk_all("rst_mid.boot", 0, 0, 0, 0, RPC, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_mid.fetch_cnt0", o_ifu_fetch_cnt, 64'd0);
        chk("rst_mid.stall_cnt0", o_ifu_stall_cnt, 64'd0);
`endif
        drive(1, 0, 32'h0, 0, 0, 1, 32'h7777_7777, 2'b00);
        chk_all("rst_mid.ar", 0, 0, 1, 0, RPC, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 1, 32'h7777_7777, 2'b00);
        chk_all("rst_mid.ar_stale", 0, 0, 1, 0, RPC, 32'h0);
        drive(1, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00);
        chk_all("rst_mid.r", 0, 0, 0, 1, RPC, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 1, 32'h0000_0093, 2'b00);
        chk_all("rst_mid.out", 0, 1, 0, 0, RPC, 32'h0000_0093);
`ifdef IFU_PERF_CNT_EN
        chk("rst_mid.fetch_cnt", o_ifu_fetch_cnt, 64'd1);
        chk("rst_mid.stall_cnt", o_ifu_stall_cnt, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
